// File: rtl/video_stream_packet_arbiter.sv
// Two-input, packet-granular round-robin arbiter for Avalon-ST video.
// A granted source keeps the output path from its SOP through its EOP.
// While idle, stray non-SOP beats are flushed. A watchdog frees a grant
// whose source has stopped sending mid-packet.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no lock; arbitrate SOP requests, flush non-SOP beats
// LOCK0 | source 0 owns the output until its EOP or a watchdog release
// LOCK1 | source 1 owns the output until its EOP or a watchdog release
module video_stream_packet_arbiter #(
    parameter int DW      = 23,
    parameter int EW      = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW:0]   in0_data,
    input  logic          in0_sop,
    input  logic          in0_eop,
    input  logic [EW:0]   in0_empty,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW:0]   in1_data,
    input  logic          in1_sop,
    input  logic          in1_eop,
    input  logic [EW:0]   in1_empty,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [DW:0]   out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [EW:0]   out_empty,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    grant,
    output logic [15:0]   frame_count,
    output logic          timeout_pulse
);

    // Watchdog counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            last_grant;
    logic            last_nx;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_nx;
    logic            load;
    logic            fire_eop;
    logic            fire_wd;
    logic            req0;
    logic            req1;
    logic            sel1;
    logic            src_valid;
    logic            src_eop;

    assign req0      = in0_valid & in0_sop;
    assign req1      = in1_valid & in1_sop;
    assign sel1      = (state == LOCK1);
    assign src_valid = sel1 ? in1_valid : in0_valid;
    assign src_eop   = sel1 ? in1_eop   : in0_eop;
    assign grant     = {state == LOCK1, state == LOCK0};

    // Arbitration, per-source ready, packet exit and watchdog decisions.
    always_comb begin
        state_nx  = state;
        last_nx   = last_grant;
        wd_nx     = wd_cnt;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        load      = 1'b0;
        fire_eop  = 1'b0;
        fire_wd   = 1'b0;
        case (state)
            IDLE: begin
                // SOP beats wait here; they are consumed only once locked.
                in0_ready = in0_valid & ~in0_sop;
                in1_ready = in1_valid & ~in1_sop;
                wd_nx     = '0;
                if (req0 && req1) begin
                    state_nx = last_grant ? LOCK0 : LOCK1;
                end else if (req0) begin
                    state_nx = LOCK0;
                end else if (req1) begin
                    state_nx = LOCK1;
                end
            end
            LOCK0, LOCK1: begin
                load = out_ready | ~out_valid;
                if (sel1) begin
                    in1_ready = load;
                end else begin
                    in0_ready = load;
                end
                if (src_valid && load) begin
                    wd_nx = '0;
                end else if (!src_valid) begin
                    if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                        fire_wd = 1'b1;
                    end else begin
                        wd_nx = wd_cnt + 1'b1;
                    end
                end
                if (src_valid && load && src_eop) begin
                    fire_eop = 1'b1;
                end
                if (fire_eop || fire_wd) begin
                    state_nx = IDLE;
                    last_nx  = sel1;
                    wd_nx    = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            in0_ready = 1'b0;
            in1_ready = 1'b0;
        end
    end

    // Lock state, round-robin history, watchdog, packet counter and pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            wd_cnt        <= '0;
            frame_count   <= 16'd0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            last_grant    <= last_nx;
            wd_cnt        <= wd_nx;
            timeout_pulse <= fire_wd;
            if (fire_eop) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Output register: loads from the locked source, drains while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= sel1 ? in1_data  : in0_data;
            out_sop   <= sel1 ? in1_sop   : in0_sop;
            out_eop   <= sel1 ? in1_eop   : in0_eop;
            out_empty <= sel1 ? in1_empty : in0_empty;
            out_valid <= src_valid;
        end else if (state == IDLE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_stream_packet_arbiter.sv
// Bench for video_stream_packet_arbiter: directed scenarios plus randomized
// two-source traffic checked against a packet-order reference model.
module tb_video_stream_packet_arbiter;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] in0_data = '0;
    logic        in0_sop = 1'b0;
    logic        in0_eop = 1'b0;
    logic [1:0]  in0_empty = '0;
    logic        in0_valid = 1'b0;
    logic        in0_ready;
    logic [23:0] in1_data = '0;
    logic        in1_sop = 1'b0;
    logic        in1_eop = 1'b0;
    logic [1:0]  in1_empty = '0;
    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic [23:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  grant;
    logic [15:0] frame_count;
    logic        timeout_pulse;

    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_frames = 0;
    int    exp_last = 1;
    beat_t pkt[$];
    beat_t b1;

    video_stream_packet_arbiter #(.DW(23), .EW(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .in0_data(in0_data), .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in0_empty(in0_empty), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_sop(in1_sop), .in1_eop(in1_eop),
        .in1_empty(in1_empty), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .frame_count(frame_count), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in0(input beat_t b, input logic v);
        in0_data = b.data; in0_sop = b.sop; in0_eop = b.eop;
        in0_empty = b.empty; in0_valid = v;
    endtask

    task automatic set_in1(input beat_t b, input logic v);
        in1_data = b.data; in1_sop = b.sop; in1_eop = b.eop;
        in1_empty = b.empty; in1_valid = v;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0;
        in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0;
    endtask

    // Packet payload carries the source id in the data MSB.
    task automatic make_pkt(input int s, input int len);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            b.data  = {s[0], 23'($urandom)};
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = 2'($urandom);
            pkt.push_back(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_frames = 0;
        exp_last = 1;
    endtask

    // Both sources keep an SOP waiting whenever they have a packet, so the
    // expected output is their packets strictly alternating.
    task automatic run_traffic(input int npk, input int first, input bit rnd);
        beat_t q0[$];
        beat_t q1[$];
        beat_t exq[$];
        beat_t e;
        int    cyc;
        int    g0;
        int    g1;
        int    other;
        int    s;
        int    len;
        bit    hold0;
        bit    hold1;
        bit    v;
        other = 1 - first;
        for (int p = 0; p < npk; p++) begin
            for (int k = 0; k < 2; k++) begin
                s = (k == 0) ? first : other;
                len = rnd ? int'($urandom_range(1, 5)) : 3;
                make_pkt(s, len);
                foreach (pkt[i]) begin
                    exq.push_back(pkt[i]);
                    if (s == 0) q0.push_back(pkt[i]);
                    else        q1.push_back(pkt[i]);
                end
            end
        end
        cyc = 0; g0 = 0; g1 = 0; hold0 = 0; hold1 = 0;
        while ((q0.size() + q1.size() + exq.size()) != 0 && cyc < 4000) begin
            if (q0.size() != 0) begin
                v = hold0 || q0[0].sop || !rnd || g0 >= 3 || ($urandom_range(0, 3) != 0);
                set_in0(q0[0], v);
                g0 = v ? 0 : g0 + 1;
            end else begin
                in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0;
            end
            if (q1.size() != 0) begin
                v = hold1 || q1[0].sop || !rnd || g1 >= 3 || ($urandom_range(0, 3) != 0);
                set_in1(q1[0], v);
                g1 = v ? 0 : g1 + 1;
            end else begin
                in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0;
            end
            out_ready = !rnd || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hold0 = in0_valid && !in0_ready;
            hold1 = in1_valid && !in1_ready;
            if (in0_valid && in0_ready) void'(q0.pop_front());
            if (in1_valid && in1_ready) void'(q1.pop_front());
            if (out_valid && out_ready) begin
                chk("rt_beat_expected", exq.size() != 0, 1);
                if (exq.size() != 0) begin
                    e = exq.pop_front();
                    chk("rt_data", out_data, e.data);
                    chk("rt_sop", out_sop, e.sop);
                    chk("rt_eop", out_eop, e.eop);
                    chk("rt_empty", out_empty, e.empty);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rt_cycle_budget", cyc < 4000, 1);
        idle_inputs();
        out_ready = 1'b1;
        exp_frames = (exp_frames + 2 * npk) & 16'hFFFF;
        exp_last = other;
        chk("rt_frame_count", frame_count, exp_frames);
        tick();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_timeout_pulse", timeout_pulse, 0);
        reset = 1'b0;
        exp_frames = 0;
        exp_last = 1;

        // Single 4-beat packet from source 0, latency and completion
        make_pkt(0, 4);
        out_ready = 1'b1;
        set_in0(pkt[0], 1'b1);
        #1;
        chk("t1_sop_held_in_idle", in0_ready, 0);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_out_not_yet", out_valid, 0);
        for (int b = 0; b < 4; b++) begin
            set_in0(pkt[b], 1'b1);
            tick();
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_data", out_data, pkt[b].data);
            chk("t1_out_sop", out_sop, pkt[b].sop);
            chk("t1_out_eop", out_eop, pkt[b].eop);
        end
        exp_frames = 1;
        exp_last = 0;
        chk("t1_grant_released", grant, 0);
        chk("t1_frame_count", frame_count, exp_frames);
        idle_inputs();
        tick();
        chk("t1_out_drained", out_valid, 0);

        // Both sources request from reset: strict alternation 0,1,0,1
        do_reset();
        run_traffic(2, 0, 1'b0);

        // Stray non-SOP beats on source 1 while idle are flushed
        for (int i = 0; i < 6; i++) begin
            in1_data = 24'h123456; in1_sop = 1'b0; in1_eop = 1'b0;
            in1_empty = 2'd0; in1_valid = 1'b1;
            #1;
            chk("t3_in1_ready", in1_ready, 1);
            tick();
            chk("t3_out_valid", out_valid, 0);
            chk("t3_grant", grant, 0);
        end
        idle_inputs();
        tick();

        // Downstream stall mid-packet: hold, no loss, no watchdog
        make_pkt(0, 6);
        set_in0(pkt[0], 1'b1);
        tick();
        chk("t4_grant", grant, 2'b01);
        tick();
        chk("t4_beat0", out_data, pkt[0].data);
        set_in0(pkt[1], 1'b1);
        tick();
        chk("t4_beat1", out_data, pkt[1].data);
        set_in0(pkt[2], 1'b1);
        out_ready = 1'b0;
        #1;
        chk("t4_in0_ready_stalled", in0_ready, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_data", out_data, pkt[1].data);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_grant", grant, 2'b01);
            chk("t4_no_timeout", timeout_pulse, 0);
        end
        out_ready = 1'b1;
        for (int b = 2; b < 6; b++) begin
            set_in0(pkt[b], 1'b1);
            tick();
            chk("t4_resume_data", out_data, pkt[b].data);
            chk("t4_resume_valid", out_valid, 1);
        end
        exp_frames++;
        exp_last = 0;
        chk("t4_grant_released", grant, 0);
        chk("t4_frame_count", frame_count, exp_frames);
        idle_inputs();
        tick();

        // Watchdog: source 0 goes silent after two beats, source 1 waits
        make_pkt(1, 1);
        b1 = pkt[0];
        make_pkt(0, 3);
        set_in0(pkt[0], 1'b1);
        tick();
        chk("t5_grant0", grant, 2'b01);
        set_in1(b1, 1'b1);
        #1;
        chk("t5_in1_blocked", in1_ready, 0);
        tick();
        set_in0(pkt[1], 1'b1);
        tick();
        in0_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("t5_still_locked", grant, 2'b01);
            chk("t5_no_pulse_yet", timeout_pulse, 0);
        end
        tick();
        chk("t5_released", grant, 0);
        chk("t5_pulse", timeout_pulse, 1);
        chk("t5_frames_unchanged", frame_count, exp_frames);
        tick();
        chk("t5_grant1", grant, 2'b10);
        chk("t5_pulse_one_cycle", timeout_pulse, 0);
        tick();
        chk("t5_in1_beat_valid", out_valid, 1);
        chk("t5_in1_beat_data", out_data, b1.data);
        chk("t5_in1_beat_sop_eop", {out_sop, out_eop}, 2'b11);
        chk("t5_grant_after_single", grant, 0);
        exp_frames++;
        exp_last = 1;
        chk("t5_frame_count", frame_count, exp_frames);
        idle_inputs();
        tick();

        // Reset while locked mid-packet
        make_pkt(0, 4);
        set_in0(pkt[0], 1'b1);
        tick();
        tick();
        set_in0(pkt[1], 1'b1);
        tick();
        set_in0(pkt[2], 1'b1);
        reset = 1'b1;
        tick();
        chk("t6_grant", grant, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_out_flags", {out_sop, out_eop, out_empty}, 0);
        chk("t6_frame_count", frame_count, 0);
        chk("t6_pulse", timeout_pulse, 0);
        chk("t6_in0_ready", in0_ready, 0);
        reset = 1'b0;
        exp_frames = 0;
        exp_last = 1;
        make_pkt(0, 2);
        set_in0(pkt[0], 1'b1);
        tick();
        chk("t6_regrant", grant, 2'b01);
        for (int b = 0; b < 2; b++) begin
            set_in0(pkt[b], 1'b1);
            tick();
            chk("t6_data", out_data, pkt[b].data);
            chk("t6_valid", out_valid, 1);
        end
        exp_frames = 1;
        exp_last = 0;
        chk("t6_frame_after", frame_count, exp_frames);
        idle_inputs();
        tick();

        // Randomized two-source traffic with gaps and backpressure
        run_traffic(6, 1 - exp_last, 1'b1);
        run_traffic(5, 1 - exp_last, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
